// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the skid-buffered pipeline stage.
//   skid_state_t : occupancy state of the two-entry stage (EMPTY, BUSY, FULL)
//   DefDataW     : default payload width
//   DefCntW      : default stall counter width
//   is_stall()   : a cycle counts as stalled when a word is offered but not taken
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefCntW  = 16;

   function automatic logic is_stall(input logic valid, input logic ready);
      return valid && !ready;
   endfunction

endpackage

// File: rtl/skid_reg.sv
// skid_reg: DATA_W-bit register with load enable and asynchronous active-high clear.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous clear, active high; forces q to zero
//   en  : load enable; q takes d on the rising edge when set
//   d   : data to load
//   q   : registered data
module skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid.sv
// pipe_skid: two-entry valid/ready pipeline stage with skid buffering.
// The upstream side only ever sees a registered in_ready, so a downstream stall
// costs one extra word of storage (the skid entry) instead of a combinational
// ready path. A saturating counter reports cycles where the consumer stalls.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset; discards both entries
//   in_valid  : upstream presents in_data
//   in_data   : upstream payload
//   in_ready  : registered; stage can accept a word this cycle
//   out_valid : registered; out_data holds a word
//   out_data  : registered payload from the main entry
//   out_ready : downstream accepts out_data
//   stall_cnt : saturating count of cycles with out_valid && !out_ready
module pipe_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned CNT_W  = DefCntW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  stall_cnt
);

   skid_state_t       state_q, state_d;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              main_en;
   logic              skid_en;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              in_fire;
   logic              out_fire;

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;

   // Next-state and entry-load decode. The main entry always feeds out_data, so
   // it is only reloaded when it is empty or its word is leaving this edge.
   always_comb begin
      state_d = state_q;
      main_en = 1'b0;
      skid_en = 1'b0;
      main_d  = in_data;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d = BUSY;
               main_en = 1'b1;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_en = 1'b1;
            end else if (in_fire) begin
               // Consumer stalled while a new word arrived: park it in skid.
               state_d = FULL;
               skid_en = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only the drain of main can happen.
            if (out_ready) begin
               state_d = BUSY;
               main_en = 1'b1;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (is_stall(out_valid_q, out_ready) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Handshake flops are computed from next_state so both outputs are plain
   // flop outputs with no path from out_ready or in_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != FULL);
         out_valid_q <= (state_d != EMPTY);
         stall_cnt_q <= stall_cnt_d;
      end
   end

   skid_reg #(
      .DATA_W (DATA_W)
   ) u_main (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
   );

   skid_reg #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk (clk),
      .rst (rst),
      .en  (skid_en),
      .d   (in_data),
      .q   (skid_q)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid.sv
// tb_pipe_skid: scenario and randomized checks of pipe_skid against a queue model.
// A second instance with a 4-bit stall counter shares all inputs to exercise
// saturation.
module tb_pipe_skid;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [15:0] stall_cnt;

   logic        in_ready_s;
   logic        out_valid_s;
   logic [7:0]  out_data_s;
   logic [3:0]  stall_cnt_s;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: an ordered queue of accepted words, capacity two.
   logic [7:0] mq[$];
   bit         m_rdy;
   logic [7:0] m_data;
   int         m_stall;

   pipe_skid #(
      .DATA_W (8),
      .CNT_W  (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .stall_cnt (stall_cnt)
   );

   pipe_skid #(
      .DATA_W (8),
      .CNT_W  (4)
   ) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready_s),
      .out_valid (out_valid_s),
      .out_data  (out_data_s),
      .out_ready (out_ready),
      .stall_cnt (stall_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] exp_cnt16();
      return (m_stall > 65535) ? 16'hFFFF : 16'(m_stall);
   endfunction

   function automatic logic [3:0] exp_cnt4();
      return (m_stall > 15) ? 4'hF : 4'(m_stall);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_rdy   = 1'b0;
      m_data  = '0;
      m_stall = 0;
   endtask

   // Drive inputs, advance one rising edge, update the model, return at the
   // following falling edge where outputs are sampled.
   task automatic tick(input logic v, input logic [7:0] d, input logic r);
      bit fi;
      bit fo;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      if (!rst) begin
         fi = v && m_rdy;
         fo = (mq.size() > 0) && r;
         if ((mq.size() > 0) && !r) m_stall++;
         if (fo) void'(mq.pop_front());
         if (fi) mq.push_back(d);
         m_rdy = (mq.size() < 2);
         if (mq.size() > 0) m_data = mq[0];
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got v=%b r=%b cnt=%0h required v=0 r=0 cnt=0",
                     i, out_valid, in_ready, stall_cnt);
         end
      end
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_pre: got in_ready=%b required 0", in_ready);
      end
      // in_valid high on the release edge must not be taken.
      tick(1'b1, 8'hEE, 1'b1);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_post: got r=%b v=%b required r=1 v=0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_stream();
      logic [7:0] words[3];
      words[0] = 8'h12;
      words[1] = 8'h34;
      words[2] = 8'h56;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, words[i], 1'b1);
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== words[i] || in_ready !== 1'b1 ||
             stall_cnt !== 16'd0 || out_data !== m_data) begin
            n_fail++;
            $display("FAIL stream[%0d]: got v=%b d=%0h r=%b cnt=%0h required v=1 d=%0h r=1 cnt=0",
                     i, out_valid, out_data, in_ready, stall_cnt, words[i]);
         end
      end
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL stream_end: got v=%b cnt=%0h required v=0 cnt=0", out_valid, stall_cnt);
      end
   endtask

   task automatic test_skid();
      tick(1'b1, 8'hAB, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hAB || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_first: got v=%b d=%0h r=%b required v=1 d=ab r=1",
                  out_valid, out_data, in_ready);
      end
      tick(1'b1, 8'hCD, 1'b0);
      n_checks++;
      if (in_ready !== 1'b0 || out_data !== 8'hAB || stall_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL skid_full: got r=%b d=%0h cnt=%0h required r=0 d=ab cnt=1",
                  in_ready, out_data, stall_cnt);
      end
      // Upstream keeps offering a word that must be ignored while full.
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 8'hEF, 1'b0);
         n_checks++;
         if (out_data !== 8'hAB || in_ready !== 1'b0 || stall_cnt !== 16'(i + 2)) begin
            n_fail++;
            $display("FAIL skid_hold[%0d]: got d=%0h r=%b cnt=%0h required d=ab r=0 cnt=%0h",
                     i, out_data, in_ready, stall_cnt, i + 2);
         end
      end
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hCD || in_ready !== 1'b1 ||
          stall_cnt !== 16'd4) begin
         n_fail++;
         $display("FAIL skid_drain1: got v=%b d=%0h r=%b cnt=%0h required v=1 d=cd r=1 cnt=4",
                  out_valid, out_data, in_ready, stall_cnt);
      end
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0 || stall_cnt !== exp_cnt16()) begin
         n_fail++;
         $display("FAIL skid_drain2: got v=%b cnt=%0h required v=0 cnt=%0h",
                  out_valid, stall_cnt, exp_cnt16());
      end
   endtask

   task automatic test_drain();
      tick(1'b1, 8'h9A, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h9A) begin
         n_fail++;
         $display("FAIL drain_word: got v=%b d=%0h required v=1 d=9a", out_valid, out_data);
      end
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 8'h00, 1'b1);
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty[%0d]: got v=%b r=%b required v=0 r=1",
                     i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 8'h78, 1'b0);
      tick(1'b1, 8'hBC, 1'b0);
      n_checks++;
      if (in_ready !== 1'b0 || out_data !== 8'h78) begin
         n_fail++;
         $display("FAIL midrst_full: got r=%b d=%0h required r=0 d=78", in_ready, out_data);
      end
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00 ||
          stall_cnt !== 16'd0 || stall_cnt_s !== 4'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got v=%b r=%b d=%0h cnt=%0h required all zero",
                  out_valid, in_ready, out_data, stall_cnt);
      end
      @(negedge clk);
      tick(1'b0, 8'h00, 1'b1);
      rst = 1'b0;
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_release: got in_ready=%b required 1", in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 8'h00, 1'b1);
         n_checks++;
         if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_ghost[%0d]: got v=%b d=%0h required v=0 d=0",
                     i, out_valid, out_data);
         end
      end
   endtask

   task automatic test_saturation();
      tick(1'b1, 8'h55, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         tick(1'b0, 8'h00, 1'b0);
         n_checks++;
         if (stall_cnt !== 16'(i) || stall_cnt_s !== ((i > 15) ? 4'hF : 4'(i))) begin
            n_fail++;
            $display("FAIL sat[%0d]: got cnt16=%0h cnt4=%0h required cnt16=%0h cnt4=%0h",
                     i, stall_cnt, stall_cnt_s, i, (i > 15) ? 15 : i);
         end
      end
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0 || stall_cnt_s !== 4'hF || stall_cnt !== 16'd20) begin
         n_fail++;
         $display("FAIL sat_end: got v=%b cnt4=%0h cnt16=%0h required v=0 cnt4=f cnt16=14",
                  out_valid, stall_cnt_s, stall_cnt);
      end
   endtask

   task automatic test_random();
      logic       v;
      logic [7:0] d;
      logic       r;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = 8'($urandom);
         r = ($urandom_range(0, 2) != 0);
         tick(v, d, r);
         n_checks++;
         if (out_valid !== (mq.size() > 0) || in_ready !== m_rdy || out_data !== m_data ||
             stall_cnt !== exp_cnt16() || stall_cnt_s !== exp_cnt4() ||
             out_valid_s !== (mq.size() > 0) || in_ready_s !== m_rdy ||
             out_data_s !== m_data) begin
            n_fail++;
            $display("FAIL random[%0d]: got v=%b r=%b d=%0h cnt=%0h/%0h required v=%b r=%b d=%0h cnt=%0h/%0h",
                     i, out_valid, in_ready, out_data, stall_cnt, stall_cnt_s,
                     mq.size() > 0, m_rdy, m_data, exp_cnt16(), exp_cnt4());
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid();
      test_drain();
      test_mid_reset();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
